mdu: RTL and testbench

MDU -- requirements
Module: mdu

---
 rtl/mdu_pkg.sv | 20 ++
 rtl/mdu.sv | 103 ++++++++++
 tb/tb_mdu.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared MDU op codes, latencies and FSM state type
package mdu_pkg;
  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8
  } mdu_op_e;
  localparam logic [3:0] MULT_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES  = 4'd10;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mdu_state_e;
  function automatic logic is_muldiv(input logic [3:0] o);
    return o == OP_MULT || o == OP_MULTU || o == OP_DIV || o == OP_DIVU;
  endfunction
endpackage

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit owning the HI/LO registers
//   clk   - clock, rising edge
//   reset - asynchronous active-low reset
//   start - one-cycle launch pulse for mult/multu/div/divu
//   op    - MDU operation code (mdu_pkg::mdu_op_e)
//   A, B  - rs/rt operands after forwarding
//   req   - exception/interrupt flush, blocks launches and mthi/mtlo
//   busy  - mult/div in flight
//   HI,LO - architectural HI/LO registers
//   out   - HI on MFHI, LO on MFLO, else 0 (combinational)
module mdu
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        req,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] out
);
  mdu_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d, op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [63:0] prod_s, prod_u;
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b, dvs, uq, ur, quot, rem;
  // Operands are latched, so the arithmetic only has to settle by the commit edge.
  assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};
  // Signed division through magnitudes: avoids the 0x80000000 / -1 overflow corner
  // and gives truncation toward zero with the remainder following the dividend.
  assign neg_a = (op_q == OP_DIV) && a_q[31];
  assign neg_b = (op_q == OP_DIV) && b_q[31];
  assign mag_a = neg_a ? -a_q : a_q;
  assign mag_b = neg_b ? -b_q : b_q;
  assign dvs   = (mag_b == 32'd0) ? 32'd1 : mag_b;
  assign uq    = mag_a / dvs;
  assign ur    = mag_a % dvs;
  assign quot  = (neg_a ^ neg_b) ? -uq : uq;
  assign rem   = neg_a ? -ur : ur;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (state_q == IDLE) begin
      if (!req && start && is_muldiv(op)) begin
        state_d = BUSY;
        cnt_d   = (op == OP_MULT || op == OP_MULTU) ? MULT_CYCLES : DIV_CYCLES;
        op_d    = op;
        a_d     = A;
        b_d     = B;
      end else if (!req && op == OP_MTHI) begin
        hi_d = A;
      end else if (!req && op == OP_MTLO) begin
        lo_d = A;
      end
    end else begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        state_d = IDLE;
        if (op_q == OP_MULT || op_q == OP_MULTU) begin
          hi_d = (op_q == OP_MULT) ? prod_s[63:32] : prod_u[63:32];
          lo_d = (op_q == OP_MULT) ? prod_s[31:0] : prod_u[31:0];
        end else if (b_q != 32'd0) begin
          hi_d = rem;
          lo_d = quot;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
  assign busy = (state_q == BUSY);
  assign HI   = hi_q;
  assign LO   = lo_q;
  assign out  = (op == OP_MFHI) ? hi_q : (op == OP_MFLO) ? lo_q : 32'd0;
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: table vectors, corner sequences and random stimulus against a cycle model
module tb_mdu;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] A, B;
  logic        req;
  logic        busy;
  logic [31:0] HI, LO, out;
  int total = 0;
  int passed = 0;
  logic [31:0] m_hi, m_lo, m_a, m_b;
  logic [3:0]  m_op;
  int          m_left;
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, hi, lo;
    int          lat;
  } vec_t;
  vec_t vecs[8];
  mdu dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .req(req), .busy(busy), .HI(HI), .LO(LO), .out(out)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask
  function automatic void mdl_commit();
    longint sa, sb;
    logic [63:0] p;
    if (m_op == 4'd1) begin
      p = 64'($signed(m_a) * longint'($signed(m_b)));
      m_hi = p[63:32];
      m_lo = p[31:0];
    end else if (m_op == 4'd2) begin
      p = {32'd0, m_a} * {32'd0, m_b};
      m_hi = p[63:32];
      m_lo = p[31:0];
    end else if (m_b != 0) begin
      sa = (m_op == 4'd3) ? longint'($signed(m_a)) : longint'({32'd0, m_a});
      sb = (m_op == 4'd3) ? longint'($signed(m_b)) : longint'({32'd0, m_b});
      m_lo = 32'(sa / sb);
      m_hi = 32'(sa % sb);
    end
  endfunction
  function automatic void mdl_step(input logic s, input logic [3:0] o, input logic [31:0] a, b, input logic r);
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) mdl_commit();
    end else if (!r) begin
      if (s && o >= 4'd1 && o <= 4'd4) begin
        m_op = o; m_a = a; m_b = b;
        m_left = (o <= 4'd2) ? 5 : 10;
      end else if (o == 4'd5) m_hi = a;
      else if (o == 4'd6) m_lo = a;
    end
  endfunction
  function automatic void mdl_reset();
    m_hi = 0; m_lo = 0; m_a = 0; m_b = 0; m_op = 0; m_left = 0;
  endfunction
  task automatic cycle(input logic s, input logic [3:0] o, input logic [31:0] a, b, input logic r);
    start = s; op = o; A = a; B = b; req = r;
    #1;
    check("busy", {31'd0, busy}, {31'd0, m_left > 0});
    check("hi", HI, m_hi);
    check("lo", LO, m_lo);
    check("out", out, (o == 4'd7) ? m_hi : (o == 4'd8) ? m_lo : 32'd0);
    @(posedge clk);
    mdl_step(s, o, a, b, r);
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
  endtask
  initial begin
    int nbusy;
    vecs[0] = '{4'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1] = '{4'd2, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2] = '{4'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[4] = '{4'd4, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10};
    vecs[5] = '{4'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
    vecs[6] = '{4'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[7] = '{4'd2, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 5};
    reset = 1'b0; start = 0; op = 0; A = 0; B = 0; req = 0;
    mdl_reset();
    repeat (2) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
    reset = 1'b1;
    for (int v = 0; v < 8; v++) begin
      cycle(1'b1, vecs[v].op, vecs[v].a, vecs[v].b, 1'b0);
      nbusy = 0;
      for (int i = 0; i < vecs[v].lat; i++) begin
        nbusy += int'(busy);
        cycle(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
      end
      check("vec_busy_cycles", 32'(nbusy), 32'(vecs[v].lat));
      check("vec_busy_done", {31'd0, busy}, 32'd0);
      check("vec_hi", HI, vecs[v].hi);
      check("vec_lo", LO, vecs[v].lo);
    end
    cycle(1'b0, 4'd5, 32'h1234, 32'd0, 1'b0);
    cycle(1'b0, 4'd6, 32'h5555, 32'd0, 1'b0);
    cycle(1'b1, 4'd4, 32'd99, 32'd0, 1'b0);
    idle(10);
    check("divzero_hi", HI, 32'h1234);
    check("divzero_lo", LO, 32'h5555);
    check("divzero_busy", {31'd0, busy}, 32'd0);
    cycle(1'b0, 4'd6, 32'hABCD, 32'd0, 1'b1);
    check("mtlo_req_lo", LO, 32'h5555);
    cycle(1'b0, 4'd6, 32'hABCD, 32'd0, 1'b0);
    cycle(1'b0, 4'd8, 32'd0, 32'd0, 1'b0);
    check("mflo_out", out, 32'hABCD);
    cycle(1'b1, 4'd1, 32'd5, 32'd5, 1'b1);
    check("start_req_busy", {31'd0, busy}, 32'd0);
    cycle(1'b1, 4'd7, 32'd5, 32'd5, 1'b0);
    check("start_badop_busy", {31'd0, busy}, 32'd0);
    cycle(1'b1, 4'd3, 32'd100, 32'd7, 1'b0);
    nbusy = 0;
    for (int i = 0; i < 12; i++) begin
      nbusy += int'(busy);
      if (i == 2) cycle(1'b1, 4'd1, 32'd3, 32'd3, 1'b0);
      else if (i == 4) cycle(1'b0, 4'd5, 32'hDEAD, 32'd0, 1'b1);
      else idle(1);
    end
    check("overlap_busy_cycles", 32'(nbusy), 32'd10);
    check("overlap_hi", HI, 32'd2);
    check("overlap_lo", LO, 32'd14);
    cycle(1'b1, 4'd3, 32'd1000, 32'd3, 1'b0);
    idle(3);
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("async_reset_busy", {31'd0, busy}, 32'd0);
    check("async_reset_hi", HI, 32'd0);
    check("async_reset_lo", LO, 32'd0);
    mdl_reset();
    @(negedge clk);
    reset = 1'b1;
    idle(12);
    check("no_commit_hi", HI, 32'd0);
    check("no_commit_lo", LO, 32'd0);
    cycle(1'b1, 4'd2, 32'd6, 32'd7, 1'b0);
    idle(5);
    check("post_reset_lo", LO, 32'd42);
    for (int i = 0; i < 600; i++) begin
      logic [31:0] ra, rb;
      logic [3:0]  ro;
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) - 32'd8 : $urandom;
      ro = 4'($urandom_range(0, 15));
      cycle(1'($urandom_range(0, 2) != 0), ro, ra, rb, ($urandom_range(0, 9) == 0));
    end
    idle(11);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
